// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    // Widest datapath the saturation helpers can describe
    localparam int unsigned MAX_W = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

    // Bits handled by each pipeline slice
    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Largest positive two's-complement value of the given width (0x7F..F)
    function automatic logic [MAX_W-1:0] SAT_MAX(input int unsigned width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of the given width (0x80..0)
    function automatic logic [MAX_W-1:0] SAT_MIN(input int unsigned width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple of full-adder cells; exposes the carry into the
// MSB so the caller can derive signed overflow.
module addsub_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    // Ripple carry through one full-adder cell per bit
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[W];
        c_msb = c[W-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, STAGES carry-ripple slices with
// one global enable. Optional macro ADDSUB_SAT_EN: saturate on signed overflow.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    op_mode_e         op;
    logic             en;
    logic [WIDTH-1:0] bx_in;

    // Per-stage register taps, indexed by stage
    logic [STAGES-1:0]            valid_t;
    logic [STAGES-1:0]            carry_t;
    logic [STAGES-1:0]            cout_t;
    logic [STAGES-1:0]            ovf_t;
    logic [STAGES-1:0][WIDTH-1:0] a_t;
    logic [STAGES-1:0][WIDTH-1:0] bx_t;
    logic [STAGES-1:0][WIDTH-1:0] sum_t;
    logic                         unused_taps;

    // Operand conditioning, global enable and output wiring
    always_comb begin
        op        = sub ? OP_SUB : OP_ADD;
        bx_in     = b ^ {WIDTH{op == OP_SUB}};
        out_valid = valid_t[LAST];
        sum       = sum_t[LAST];
        cout      = cout_t[LAST];
        ovf       = ovf_t[LAST];
        in_ready  = !out_valid || out_ready;
        en        = in_ready;
    end

    // Last-stage operand/carry copies and early-stage flags are never consumed
    assign unused_taps = ^{a_t, bx_t, carry_t, cout_t, ovf_t};

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic             src_valid;
        logic             src_cin;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_bx;
        logic [WIDTH-1:0] src_sum;
        logic [SLICE-1:0] sl_s;
        logic             sl_cout;
        logic             sl_cmsb;
        logic             valid_d, valid_q;
        logic             carry_d, carry_q;
        logic             cout_d, cout_q;
        logic             ovf_d, ovf_q;
        logic [WIDTH-1:0] a_d, a_q;
        logic [WIDTH-1:0] bx_d, bx_q;
        logic [WIDTH-1:0] sum_d, sum_q;

        if (k == 0) begin : g_head
            // Stage 0 works on live operands; the mode bit is the carry-in
            always_comb begin
                src_valid = in_valid && in_ready;
                src_cin   = sub;
                src_a     = a;
                src_bx    = bx_in;
                src_sum   = '0;
            end
        end else begin : g_body
            // Later stages work on the operation delayed in the previous stage
            always_comb begin
                src_valid = valid_t[k-1];
                src_cin   = carry_t[k-1];
                src_a     = a_t[k-1];
                src_bx    = bx_t[k-1];
                src_sum   = sum_t[k-1];
            end
        end

        addsub_slice #(
            .W (SLICE)
        ) u_slice (
            .a     (src_a[k*SLICE +: SLICE]),
            .b     (src_bx[k*SLICE +: SLICE]),
            .cin   (src_cin),
            .s     (sl_s),
            .cout  (sl_cout),
            .c_msb (sl_cmsb)
        );

        // Merge this slice into the partial result and derive the flags
        always_comb begin
            valid_d                 = src_valid;
            carry_d                 = sl_cout;
            a_d                     = src_a;
            bx_d                    = src_bx;
            sum_d                   = src_sum;
            sum_d[k*SLICE +: SLICE] = sl_s;
            cout_d                  = sl_cout;
            ovf_d                   = sl_cmsb ^ sl_cout;
`ifdef ADDSUB_SAT_EN
            if ((k == LAST) && ovf_d) begin
                sum_d = src_a[WIDTH-1] ? WIDTH'(SAT_MIN(WIDTH)) : WIDTH'(SAT_MAX(WIDTH));
            end
`endif
        end

        // Stage register: loads only on the global enable
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                cout_q  <= 1'b0;
                ovf_q   <= 1'b0;
                a_q     <= '0;
                bx_q    <= '0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                cout_q  <= cout_d;
                ovf_q   <= ovf_d;
                a_q     <= a_d;
                bx_q    <= bx_d;
                sum_q   <= sum_d;
            end
        end

        assign valid_t[k] = valid_q;
        assign carry_t[k] = carry_q;
        assign cout_t[k]  = cout_q;
        assign ovf_t[k]   = ovf_q;
        assign a_t[k]     = a_q;
        assign bx_t[k]    = bx_q;
        assign sum_t[k]   = sum_q;
    end

endmodule
